// File: rtl/mips_pipeline_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_pipeline_controller : 4-stage MIPS hazard/flush/debug sequencer
// Revision 1.0
// ---------------------------------------------------------------------------
module mips_pipeline_controller #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       dof_addr_a,
  input  logic             dof_use_a,
  input  logic [4:0]       dof_addr_b,
  input  logic             dof_use_b,
  input  logic             dof_rw,
  input  logic [4:0]       dof_addr_d,
  input  logic             ex_taken,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             pc_en,
  output logic             ir_en,
  output logic             bubble,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2,
    S_STEP   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_nxt;
  logic          step_prev;
  logic          ex_rw, wb_rw;
  logic [4:0]    ex_dest, wb_dest;
  logic          hazard_a, hazard_b, hazard, step_rise;
  logic          stall_inc, flush_inc;

  // Writes still in EX or WB are not yet visible in the register file.
  assign hazard_a = dof_use_a && (dof_addr_a != 5'd0) &&
                    ((ex_rw && (ex_dest == dof_addr_a)) ||
                     (wb_rw && (wb_dest == dof_addr_a)));
  assign hazard_b = dof_use_b && (dof_addr_b != 5'd0) &&
                    ((ex_rw && (ex_dest == dof_addr_b)) ||
                     (wb_rw && (wb_dest == dof_addr_b)));
  assign hazard    = hazard_a || hazard_b;
  assign step_rise = step_req && !step_prev;
  assign halted    = (state == S_HALTED);

  always_comb begin
    pc_en     = 1'b1;
    ir_en     = 1'b1;
    bubble    = 1'b0;
    flush     = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    state_nxt = state;
    drain_nxt = drain_cnt;

    if (ex_taken) begin
      bubble    = 1'b1;
      flush     = 1'b1;
      flush_inc = 1'b1;
    end else if (state == S_DRAIN || state == S_HALTED) begin
      pc_en  = 1'b0;
      ir_en  = 1'b0;
      bubble = 1'b1;
    end else if (hazard) begin
      pc_en     = 1'b0;
      ir_en     = 1'b0;
      bubble    = 1'b1;
      stall_inc = 1'b1;
    end

    case (state)
      S_RUN: begin
        if (halt_req) begin
          state_nxt = S_DRAIN;
          drain_nxt = DW'(DRAIN_CYCLES);
        end
      end
      S_DRAIN: begin
        if (drain_cnt <= DW'(1)) state_nxt = S_HALTED;
        else                     drain_nxt = drain_cnt - DW'(1);
      end
      S_HALTED: begin
        if (!halt_req)      state_nxt = S_RUN;
        else if (step_rise) state_nxt = S_STEP;
      end
      S_STEP: begin
        // A squashing branch still advances the PC, so it ends the step.
        if (ex_taken || !hazard) begin
          state_nxt = S_DRAIN;
          drain_nxt = DW'(DRAIN_CYCLES);
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_RUN;
      drain_cnt   <= '0;
      step_prev   <= 1'b0;
      ex_rw       <= 1'b0;
      ex_dest     <= 5'd0;
      wb_rw       <= 1'b0;
      wb_dest     <= 5'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      step_prev <= step_req;
      wb_rw     <= ex_rw;
      wb_dest   <= ex_dest;
      ex_rw     <= bubble ? 1'b0 : dof_rw;
      ex_dest   <= bubble ? 5'd0 : dof_addr_d;
      if (stall_inc && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flush_inc && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_pipeline_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mips_pipeline_controller : directed vectors with queued expectations
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mips_pipeline_controller;

  localparam int CNT_W = 16;

  logic             clock, reset;
  logic [4:0]       dof_addr_a, dof_addr_b, dof_addr_d;
  logic             dof_use_a, dof_use_b, dof_rw, ex_taken, halt_req, step_req;
  logic             pc_en, ir_en, bubble, flush, halted;
  logic [CNT_W-1:0] stall_count, flush_count;

  mips_pipeline_controller #(.CNT_W(CNT_W), .DRAIN_CYCLES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .dof_addr_a  (dof_addr_a),
    .dof_use_a   (dof_use_a),
    .dof_addr_b  (dof_addr_b),
    .dof_use_b   (dof_use_b),
    .dof_rw      (dof_rw),
    .dof_addr_d  (dof_addr_d),
    .ex_taken    (ex_taken),
    .halt_req    (halt_req),
    .step_req    (step_req),
    .pc_en       (pc_en),
    .ir_en       (ir_en),
    .bubble      (bubble),
    .flush       (flush),
    .halted      (halted),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  typedef struct packed {
    logic [4:0]       ctl;   // pc_en, ir_en, bubble, flush, halted
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  logic  stim_done = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Monitor: pulls one expectation per cycle, 2 time units after posedge.
  initial begin
    exp_t  e, a;
    string nm;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '{ctl: {pc_en, ir_en, bubble, flush, halted}, sc: stall_count, fc: flush_count};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got ctl=%b stall=%0d flush=%0d, expected ctl=%b stall=%0d flush=%0d",
                   nm, a.ctl, a.sc, a.fc, e.ctl, e.sc, e.fc);
        end
      end
    end
  end

  task automatic push(input string nm, input logic [4:0] ctl, input int sc, input int fc);
    exp_q.push_back('{ctl: ctl, sc: CNT_W'(sc), fc: CNT_W'(fc)});
    name_q.push_back(nm);
  endtask

  task automatic idle_inputs();
    dof_use_a = 1'b0; dof_addr_a = 5'd0;
    dof_use_b = 1'b0; dof_addr_b = 5'd0;
    dof_rw    = 1'b0; dof_addr_d = 5'd0;
    ex_taken  = 1'b0; halt_req   = 1'b0; step_req = 1'b0;
  endtask

  // Drive one DOF cycle at posedge; state advances at the following negedge.
  task automatic cyc(input string nm,
                     input logic ua, input logic [4:0] a,
                     input logic ub, input logic [4:0] b,
                     input logic rw, input logic [4:0] d,
                     input logic tk, input logic hr, input logic sr,
                     input logic [4:0] ctl, input int sc, input int fc);
    @(posedge clock);
    dof_use_a = ua; dof_addr_a = a;
    dof_use_b = ub; dof_addr_b = b;
    dof_rw    = rw; dof_addr_d = d;
    ex_taken  = tk; halt_req   = hr; step_req = sr;
    push(nm, ctl, sc, fc);
  endtask

  // Reset asserted and released away from either clock edge.
  task automatic do_reset(input string nm);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle_inputs();
    push(nm, 5'b11000, 0, 0);
    @(negedge clock);
    #1;
    reset = 1'b1;
  endtask

  localparam logic [4:0] ISSUE = 5'b11000;
  localparam logic [4:0] STALL = 5'b00100;
  localparam logic [4:0] SQUASH = 5'b11110;
  localparam logic [4:0] HALT  = 5'b00101;

  initial begin
    reset = 1'b0;
    idle_inputs();

    // Distance-1 dependency: two stall cycles
    do_reset("reset_t1");
    cyc("d1_writer", 0,0, 0,0, 1,3, 0,0,0, ISSUE, 0, 0);
    cyc("d1_stall1", 1,3, 0,0, 0,0, 0,0,0, STALL, 0, 0);
    cyc("d1_stall2", 1,3, 0,0, 0,0, 0,0,0, STALL, 1, 0);
    cyc("d1_issue",  1,3, 0,0, 0,0, 0,0,0, ISSUE, 2, 0);
    cyc("d1_count",  0,0, 0,0, 0,0, 0,0,0, ISSUE, 2, 0);

    // Distance-2 dependency on port B: one stall cycle
    do_reset("reset_t2");
    cyc("d2_writer", 0,0, 0,0, 1,3, 0,0,0, ISSUE, 0, 0);
    cyc("d2_indep",  1,7, 0,0, 1,5, 0,0,0, ISSUE, 0, 0);
    cyc("d2_stall",  0,0, 1,3, 0,0, 0,0,0, STALL, 0, 0);
    cyc("d2_issue",  0,0, 1,3, 0,0, 0,0,0, ISSUE, 1, 0);
    cyc("d2_count",  0,0, 0,0, 0,0, 0,0,0, ISSUE, 1, 0);

    // Register 0 and unused source ports never stall
    do_reset("reset_t3");
    cyc("r0_writer", 0,0, 0,0, 1,0, 0,0,0, ISSUE, 0, 0);
    cyc("r0_read1",  1,0, 1,0, 0,0, 0,0,0, ISSUE, 0, 0);
    cyc("r0_read2",  1,0, 1,0, 0,0, 0,0,0, ISSUE, 0, 0);
    cyc("nouse_wr",  0,0, 0,0, 1,4, 0,0,0, ISSUE, 0, 0);
    cyc("nouse_rd",  0,4, 0,4, 0,0, 0,0,0, ISSUE, 0, 0);

    // Taken branch overrides a hazard and squashes the DOF write
    do_reset("reset_t4");
    cyc("br_writer", 0,0, 0,0, 1,3, 0,0,0, ISSUE,  0, 0);
    cyc("br_taken",  1,3, 0,0, 1,6, 1,0,0, SQUASH, 0, 0);
    cyc("br_no_ex",  1,6, 0,0, 0,0, 0,0,0, ISSUE,  0, 1);
    cyc("br_count",  0,0, 0,0, 0,0, 0,0,0, ISSUE,  0, 1);

    // Halt, single step, resume
    do_reset("reset_t5");
    cyc("h_req",     0,0, 0,0, 0,0, 0,1,0, ISSUE, 0, 0);
    cyc("h_drain1",  0,0, 0,0, 0,0, 0,1,0, STALL, 0, 0);
    cyc("h_drain2",  0,0, 0,0, 0,0, 0,1,0, STALL, 0, 0);
    cyc("h_halted",  0,0, 0,0, 0,0, 0,1,0, HALT,  0, 0);
    cyc("h_steprise",0,0, 0,0, 0,0, 0,1,1, HALT,  0, 0);
    cyc("s_issue",   0,0, 0,0, 0,0, 0,1,0, ISSUE, 0, 0);
    cyc("s_drain1",  0,0, 0,0, 0,0, 0,1,0, STALL, 0, 0);
    cyc("s_drain2",  0,0, 0,0, 0,0, 0,1,0, STALL, 0, 0);
    cyc("s_halted",  0,0, 0,0, 0,0, 0,1,0, HALT,  0, 0);
    cyc("h_release", 0,0, 0,0, 0,0, 0,0,0, HALT,  0, 0);
    cyc("h_run",     0,0, 0,0, 0,0, 0,0,0, ISSUE, 0, 0);
    cyc("run_step1", 0,0, 0,0, 0,0, 0,0,1, ISSUE, 0, 0);
    cyc("run_step0", 0,0, 0,0, 0,0, 0,0,0, ISSUE, 0, 0);

    // Halt completes even if the request drops mid-drain
    do_reset("reset_t6");
    cyc("hd_req",    0,0, 0,0, 0,0, 0,1,0, ISSUE, 0, 0);
    cyc("hd_drop1",  0,0, 0,0, 0,0, 0,0,0, STALL, 0, 0);
    cyc("hd_drop2",  0,0, 0,0, 0,0, 0,0,0, STALL, 0, 0);
    cyc("hd_halted", 0,0, 0,0, 0,0, 0,0,0, HALT,  0, 0);
    cyc("hd_run",    0,0, 0,0, 0,0, 0,0,0, ISSUE, 0, 0);

    // Asynchronous reset in the middle of a drain
    do_reset("reset_t7");
    cyc("rm_branch", 0,0, 0,0, 0,0, 1,0,0, SQUASH, 0, 0);
    cyc("rm_halt",   0,0, 0,0, 1,3, 0,1,0, ISSUE,  0, 1);
    cyc("rm_drain",  1,3, 0,0, 0,0, 0,1,0, STALL,  0, 1);
    do_reset("rm_async_reset");
    cyc("rm_sb_empty", 1,3, 0,0, 0,0, 0,0,0, ISSUE, 0, 0);

    stim_done = 1'b1;
  end

  initial begin
    int waited;
    waited = 0;
    wait (stim_done);
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clock);
      waited++;
    end
    repeat (2) @(posedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mips_pipeline_controller.md
Name: mips_pipeline_controller

Overview:
- Sequencing controller for the four-stage MIPS pipeline: instruction fetch, decode/operand fetch (DOF), execute (EX) and writeback (WB).
- Keeps a two-entry scoreboard of in-flight register writes and stalls DOF on read-after-write hazards.
- Squashes wrong-path instructions when EX resolves a taken branch or jump.
- Provides a debug halt/single-step FSM.
- Drives the pipeline-register enables and bubble/flush controls; performs no datapath arithmetic itself.

Parameters:
- CNT_W, 16, width of the saturating stall and flush event counters.
- DRAIN_CYCLES, 2, bubble cycles issued after a halt request before halted asserts. Minimum 1.

Ports:
- clock  in  1  pipeline clock. All state updates on the falling edge, matching the pipeline registers.
- reset  in  1  asynchronous, active-low. reset=0 clears all state immediately.
- dof_addr_a  in  5  source register A of the instruction in DOF.
- dof_use_a  in  1  DOF instruction reads register A from the register file (not PC).
- dof_addr_b  in  5  source register B of the instruction in DOF.
- dof_use_b  in  1  DOF instruction reads register B from the register file (not the constant).
- dof_rw  in  1  DOF instruction writes the register file.
- dof_addr_d  in  5  destination register of the DOF instruction.
- ex_taken  in  1  branch/jump in EX resolved taken this cycle.
- halt_req  in  1  debug halt request, level.
- step_req  in  1  debug single-step request. Only its rising edge acts.
- pc_en  out  1  PC and pc pipeline registers load.
- ir_en  out  1  instruction register loads.
- bubble  out  1  DOF-to-EX control word forced to zero (no write, no memory write, no branch).
- flush  out  1  instruction register loads zero instead of instruction memory data.
- halted  out  1  pipeline drained and stopped.
- stall_count  out  CNT_W  number of hazard stall cycles.
- flush_count  out  CNT_W  number of taken-branch flushes.

Behaviour:
- Reset values:
  - State RUN; scoreboard empty (ex_rw=0, wb_rw=0).
  - Counters 0; step edge detector cleared.
  - Outputs: pc_en=1, ir_en=1, bubble=0, flush=0, halted=0.
- Scoreboard: ex_rw/ex_dest and wb_rw/wb_dest.
  - Each falling edge: wb <= ex; ex <= (bubble ? {0,x} : {dof_rw, dof_addr_d}).
- Hazard (combinational): for each source X in {a, b}, a hazard exists when dof_use_X=1, dof_addr_X!=0, and either (ex_rw and ex_dest==dof_addr_X) or (wb_rw and wb_dest==dof_addr_X).
  - Register 0 never causes a hazard.
- Priority, highest first:
  - reset
  - ex_taken
  - HALTED/DRAIN hold
  - hazard
  - normal issue
- ex_taken=1, any state:
  - pc_en=1, ir_en=1, flush=1, bubble=1.
  - flush_count increments, saturating at all-ones.
  - Hazard is ignored that cycle, because the DOF instruction is squashed.
- Hazard in RUN or STEP: pc_en=0, ir_en=0, bubble=1, flush=0. stall_count increments, saturating.
- Normal issue: pc_en=1, ir_en=1, bubble=0, flush=0.
- A stall lasts until the matching write has left WB: at most 2 cycles per instruction.
- FSM states: RUN, DRAIN, HALTED, STEP.
  - RUN: halt_req=1 -> DRAIN with drain counter=DRAIN_CYCLES.
  - DRAIN: pc_en=0, ir_en=0, bubble=1 unless ex_taken. Counter decrements each cycle; at 1 -> HALTED. Stall cycles during DRAIN are not counted. halt_req dropping during DRAIN does not abort; completes to HALTED.
  - HALTED: halted=1, pc_en=0, ir_en=0, bubble=1.
    - halt_req=0 -> RUN.
    - Rising edge of step_req with halt_req=1 -> STEP.
  - STEP: one normal-issue attempt.
    - On hazard, remain in STEP (counted stall).
    - Once issued -> DRAIN, which re-drains, then HALTED.
- step_req edges in RUN or DRAIN are ignored and not queued.
- Asynchronous reset mid-drain or mid-step returns to RUN with an empty scoreboard the same instant.

Test Plan:
- Dependency at distance 1: decode writes r3 (dof_rw=1, dof_addr_d=3); next DOF reads r3 on A.
  -> Exactly 2 cycles of pc_en=0/bubble=1, then issue. stall_count=2.
- Dependency at distance 2: one independent instruction between writer and reader of r3.
  -> Exactly 1 stall cycle. stall_count=1.
- Register 0: DOF reads r0 after a write to r0 -> no stall. stall_count=0.
- Branch with simultaneous hazard: ex_taken=1 while DOF has a hazard.
  -> pc_en=1, flush=1, bubble=1. flush_count=1, stall_count unchanged.
  -> Next cycle's ex_rw=0.
- Halt and single step:
  -> halt_req=1 -> halted=1 after exactly DRAIN_CYCLES=2 cycles.
  -> One step_req pulse -> exactly one pc_en=1 cycle, then halted=1 again 2 cycles later.
  -> halt_req=0 -> RUN on the next edge.
- Reset mid-DRAIN: assert reset=0 asynchronously, not on a clock edge.
  -> Outputs return to pc_en=1, halted=0 and counters read 0 before the next edge.
